// File: rtl/risc_execute.sv
// Single-issue execute stage: eight-entry register file, ALU with Z/C/N flags,
// retired-instruction counter and a store channel that stalls decode while busy.
module risc_execute #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dec_valid,
  output logic          dec_ready,
  input  logic [3:0]    opcode,
  input  logic [2:0]    opnda,
  input  logic [2:0]    opndb,
  input  logic [2:0]    dst,
  output logic          st_valid,
  input  logic          st_ready,
  output logic [DW-1:0] st_data,
  output logic [2:0]    st_addr,
  output logic          flag_z,
  output logic          flag_c,
  output logic          flag_n,
  input  logic [2:0]    dbg_sel,
  output logic [DW-1:0] dbg_data,
  output logic [15:0]   retired
);

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;
  localparam logic [3:0] OP_INC = 4'h6;
  localparam logic [3:0] OP_DEC = 4'h7;
  localparam logic [3:0] OP_NOT = 4'h8;
  localparam logic [3:0] OP_NEG = 4'h9;
  localparam logic [3:0] OP_SHR = 4'hA;
  localparam logic [3:0] OP_SHL = 4'hB;
  localparam logic [3:0] OP_ROR = 4'hC;
  localparam logic [3:0] OP_ROL = 4'hD;
  localparam logic [3:0] OP_LDI = 4'hE;
  localparam logic [3:0] OP_ST  = 4'hF;

  logic [DW-1:0] r_regs [8];
  state_t        r_state;
  logic          r_st_valid;
  logic [DW-1:0] r_st_data;
  logic [2:0]    r_st_addr;
  logic          r_flag_z;
  logic          r_flag_c;
  logic          r_flag_n;
  logic [15:0]   r_retired;

  logic [DW-1:0] w_a;
  logic [DW-1:0] w_b;
  logic [DW-1:0] w_res;
  logic          w_c;
  logic          w_wr;
  logic          w_accept;
  logic          w_is_st;

  assign w_a      = r_regs[opnda];
  assign w_b      = r_regs[opndb];
  assign dec_ready = (r_state == RUN) || st_ready;
  assign w_accept = dec_valid && dec_ready;
  assign w_is_st  = (opcode == OP_ST);

  assign st_valid = r_st_valid;
  assign st_data  = r_st_data;
  assign st_addr  = r_st_addr;
  assign flag_z   = r_flag_z;
  assign flag_c   = r_flag_c;
  assign flag_n   = r_flag_n;
  assign retired  = r_retired;
  assign dbg_data = r_regs[dbg_sel];

  // ALU: result, carry/borrow and write-enable for the decoded opcode
  always_comb begin
    w_res = {DW{1'b0}};
    w_c   = 1'b0;
    w_wr  = 1'b0;
    case (opcode)
      OP_ADD: begin
        {w_c, w_res} = {1'b0, w_a} + {1'b0, w_b};
        w_wr = 1'b1;
      end
      OP_SUB: begin
        // the extra top bit of the widened difference is the borrow
        {w_c, w_res} = {1'b0, w_a} - {1'b0, w_b};
        w_wr = 1'b1;
      end
      OP_AND: begin
        w_res = w_a & w_b;
        w_wr  = 1'b1;
      end
      OP_OR: begin
        w_res = w_a | w_b;
        w_wr  = 1'b1;
      end
      OP_XOR: begin
        w_res = w_a ^ w_b;
        w_wr  = 1'b1;
      end
      OP_INC: begin
        {w_c, w_res} = {1'b0, w_a} + {{DW{1'b0}}, 1'b1};
        w_wr = 1'b1;
      end
      OP_DEC: begin
        {w_c, w_res} = {1'b0, w_a} - {{DW{1'b0}}, 1'b1};
        w_wr = 1'b1;
      end
      OP_NOT: begin
        w_res = ~w_a;
        w_wr  = 1'b1;
      end
      OP_NEG: begin
        w_res = {DW{1'b0}} - w_a;
        w_c   = |w_a;
        w_wr  = 1'b1;
      end
      OP_SHR: begin
        w_res = {1'b0, w_a[DW-1:1]};
        w_c   = w_a[0];
        w_wr  = 1'b1;
      end
      OP_SHL: begin
        w_res = {w_a[DW-2:0], 1'b0};
        w_c   = w_a[DW-1];
        w_wr  = 1'b1;
      end
      OP_ROR: begin
        w_res = {w_a[0], w_a[DW-1:1]};
        w_c   = w_a[0];
        w_wr  = 1'b1;
      end
      OP_ROL: begin
        w_res = {w_a[DW-2:0], w_a[DW-1]};
        w_c   = w_a[DW-1];
        w_wr  = 1'b1;
      end
      OP_LDI: begin
        w_res = DW'({opnda, opndb});
        w_wr  = 1'b1;
      end
      default: begin
        w_res = {DW{1'b0}};
        w_c   = 1'b0;
        w_wr  = 1'b0;
      end
    endcase
  end

  // Register file, flags and retired counter update on an accepted instruction
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        r_regs[i] <= {DW{1'b0}};
      end
      r_flag_z  <= 1'b0;
      r_flag_c  <= 1'b0;
      r_flag_n  <= 1'b0;
      r_retired <= 16'd0;
    end else if (w_accept) begin
      if (w_wr) begin
        r_regs[dst] <= w_res;
        r_flag_z    <= (w_res == {DW{1'b0}});
        r_flag_c    <= w_c;
        r_flag_n    <= w_res[DW-1];
      end
      if (opcode != OP_NOP) begin
        r_retired <= r_retired + 16'd1;
      end
    end
  end

  // Store-channel FSM with registered st_valid/st_data/st_addr
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= RUN;
      r_st_valid <= 1'b0;
      r_st_data  <= {DW{1'b0}};
      r_st_addr  <= 3'd0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_accept && w_is_st) begin
            r_state    <= ST_WAIT;
            r_st_valid <= 1'b1;
            r_st_data  <= w_a;
            r_st_addr  <= dst;
          end
        end
        ST_WAIT: begin
          // decode can only be accepted here when st_ready is high
          if (st_ready) begin
            if (w_accept && w_is_st) begin
              r_st_data <= w_a;
              r_st_addr <= dst;
            end else begin
              r_state    <= RUN;
              r_st_valid <= 1'b0;
            end
          end
        end
        default: begin
          r_state    <= RUN;
          r_st_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_risc_execute.sv
// Randomized bench for risc_execute against an arithmetic reference model,
// with directed sequences pinning the model to hand-computed values.
module tb_risc_execute;
  localparam int DW = 8;
  localparam int M  = 1 << DW;

  logic          clk;
  logic          rst;
  logic          dec_valid;
  logic          dec_ready;
  logic [3:0]    opcode;
  logic [2:0]    opnda;
  logic [2:0]    opndb;
  logic [2:0]    dst;
  logic          st_valid;
  logic          st_ready;
  logic [DW-1:0] st_data;
  logic [2:0]    st_addr;
  logic          flag_z;
  logic          flag_c;
  logic          flag_n;
  logic [2:0]    dbg_sel;
  logic [DW-1:0] dbg_data;
  logic [15:0]   retired;

  risc_execute #(.DW(DW)) dut (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .opcode(opcode), .opnda(opnda), .opndb(opndb), .dst(dst),
    .st_valid(st_valid), .st_ready(st_ready), .st_data(st_data), .st_addr(st_addr),
    .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int m_r [8];
  int m_z, m_c, m_n, m_ret;
  int m_stw, m_sd, m_sa;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) m_r[i] = 0;
    m_z = 0; m_c = 0; m_n = 0; m_ret = 0;
    m_stw = 0; m_sd = 0; m_sa = 0;
  endfunction

  // Reference ALU in plain integer arithmetic
  function automatic void alu(input int op, input int a, input int b, input int imm,
                              output int res, output int c, output bit wr);
    int s;
    wr = 1'b1; c = 0; res = 0;
    case (op)
      1:  begin s = a + b; res = s % M; c = (s >= M) ? 1 : 0; end
      2:  begin res = (a - b + M) % M; c = (a < b) ? 1 : 0; end
      3:  res = a & b;
      4:  res = a | b;
      5:  res = a ^ b;
      6:  begin s = a + 1; res = s % M; c = (s >= M) ? 1 : 0; end
      7:  begin res = (a - 1 + M) % M; c = (a == 0) ? 1 : 0; end
      8:  res = M - 1 - a;
      9:  begin res = (M - a) % M; c = (a != 0) ? 1 : 0; end
      10: begin res = a / 2; c = a % 2; end
      11: begin res = (a * 2) % M; c = (a >= M / 2) ? 1 : 0; end
      12: begin res = a / 2 + (a % 2) * (M / 2); c = a % 2; end
      13: begin res = (a * 2) % M + ((a >= M / 2) ? 1 : 0); c = (a >= M / 2) ? 1 : 0; end
      14: res = imm % M;
      default: wr = 1'b0;
    endcase
  endfunction

  // Advance the model across the coming clock edge using the driven inputs
  function automatic void model_step();
    int res, c, a, b;
    bit wr, acc;
    if (rst) begin
      model_reset();
      return;
    end
    acc = dec_valid && ((m_stw == 0) || st_ready);
    if (m_stw != 0 && st_ready) m_stw = 0;
    if (!acc) return;
    a = m_r[opnda];
    b = m_r[opndb];
    if (opcode != 4'd0) m_ret = (m_ret + 1) % 65536;
    if (opcode == 4'd15) begin
      m_stw = 1; m_sd = a; m_sa = int'(dst);
    end else begin
      alu(int'(opcode), a, b, int'(opnda) * 8 + int'(opndb), res, c, wr);
      if (wr) begin
        m_r[dst] = res;
        m_c = c;
        m_z = (res == 0) ? 1 : 0;
        m_n = (res >= M / 2) ? 1 : 0;
      end
    end
  endfunction

  task automatic compare_all();
    chk("dec_ready", int'(dec_ready), ((m_stw == 0) || st_ready) ? 1 : 0);
    chk("st_valid", int'(st_valid), m_stw);
    chk("st_data", int'(st_data), m_sd);
    chk("st_addr", int'(st_addr), m_sa);
    chk("flag_z", int'(flag_z), m_z);
    chk("flag_c", int'(flag_c), m_c);
    chk("flag_n", int'(flag_n), m_n);
    chk("retired", int'(retired), m_ret);
    chk("dbg_data", int'(dbg_data), m_r[dbg_sel]);
  endtask

  // One cycle: drive on the falling edge, compare against the model, step it
  task automatic drv(input logic v, input logic [3:0] op, input logic [2:0] a,
                     input logic [2:0] b, input logic [2:0] d, input logic sr,
                     input logic r, input logic [2:0] ds);
    @(negedge clk);
    dec_valid = v; opcode = op; opnda = a; opndb = b; dst = d;
    st_ready = sr; rst = r; dbg_sel = ds;
    #1;
    compare_all();
    model_step();
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; dec_valid = 1'b0; opcode = 4'd0; opnda = 3'd0; opndb = 3'd0;
    dst = 3'd0; st_ready = 1'b0; dbg_sel = 3'd0;
    model_reset();
    repeat (2) @(posedge clk);

    // reset state and first cycle after reset release
    drv(1'b0, 4'd0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0);
    chk("rst_dec_ready", int'(dec_ready), 1);
    chk("rst_st_valid", int'(st_valid), 0);
    chk("rst_retired", int'(retired), 0);

    // LDI R1 = {000,101}
    drv(1'b1, 4'hE, 3'd0, 3'd5, 3'd1, 1'b1, 1'b0, 3'd1);
    after_edge();
    chk("ldi_r1", int'(dbg_data), 8'h05);
    chk("ldi_z", int'(flag_z), 0);
    chk("ldi_c", int'(flag_c), 0);
    chk("ldi_n", int'(flag_n), 0);
    chk("ldi_retired", int'(retired), 1);

    // LDI R1=1, NEG R2=-R1, INC R3=R2+1
    drv(1'b1, 4'hE, 3'd0, 3'd1, 3'd1, 1'b1, 1'b0, 3'd2);
    drv(1'b1, 4'h9, 3'd1, 3'd0, 3'd2, 1'b1, 1'b0, 3'd2);
    after_edge();
    chk("neg_r2", int'(dbg_data), 8'hFF);
    chk("neg_c", int'(flag_c), 1);
    chk("neg_n", int'(flag_n), 1);
    drv(1'b1, 4'h6, 3'd2, 3'd0, 3'd3, 1'b1, 1'b0, 3'd3);
    after_edge();
    chk("inc_r3", int'(dbg_data), 8'h00);
    chk("inc_z", int'(flag_z), 1);
    chk("inc_c", int'(flag_c), 1);

    // back-to-back LDI R1=3 then ADD R2=R1+R1 uses the fresh value
    drv(1'b1, 4'hE, 3'd0, 3'd3, 3'd1, 1'b1, 1'b0, 3'd2);
    drv(1'b1, 4'h1, 3'd1, 3'd1, 3'd2, 1'b1, 1'b0, 3'd2);
    after_edge();
    chk("add_r2", int'(dbg_data), 8'h06);

    // ST R2 -> addr 5 while st_ready is low; pending INC R4 must wait
    drv(1'b1, 4'hF, 3'd2, 3'd0, 3'd5, 1'b0, 1'b0, 3'd4);
    for (int k = 0; k < 3; k++) begin
      drv(1'b1, 4'h6, 3'd1, 3'd0, 3'd4, 1'b0, 1'b0, 3'd4);
      after_edge();
      chk("stall_st_valid", int'(st_valid), 1);
      chk("stall_st_data", int'(st_data), 8'h06);
      chk("stall_st_addr", int'(st_addr), 5);
      chk("stall_dec_ready", int'(dec_ready), 0);
      chk("stall_r4", int'(dbg_data), 8'h00);
    end
    drv(1'b1, 4'h6, 3'd1, 3'd0, 3'd4, 1'b1, 1'b0, 3'd4);
    after_edge();
    chk("release_r4", int'(dbg_data), 8'h04);
    chk("release_st_valid", int'(st_valid), 0);
    chk("release_retired", int'(retired), 8);

    // R1 = 0x81 via LDI 0x3F, SHL, INC, NEG; then ROL and SHR of 1
    drv(1'b1, 4'hE, 3'd7, 3'd7, 3'd1, 1'b1, 1'b0, 3'd1);
    drv(1'b1, 4'hB, 3'd1, 3'd0, 3'd1, 1'b1, 1'b0, 3'd1);
    drv(1'b1, 4'h6, 3'd1, 3'd0, 3'd1, 1'b1, 1'b0, 3'd1);
    drv(1'b1, 4'h9, 3'd1, 3'd0, 3'd1, 1'b1, 1'b0, 3'd1);
    after_edge();
    chk("seq_r1", int'(dbg_data), 8'h81);
    drv(1'b1, 4'hD, 3'd1, 3'd0, 3'd6, 1'b1, 1'b0, 3'd6);
    after_edge();
    chk("rol_r6", int'(dbg_data), 8'h03);
    chk("rol_c", int'(flag_c), 1);
    drv(1'b1, 4'hE, 3'd0, 3'd1, 3'd7, 1'b1, 1'b0, 3'd7);
    drv(1'b1, 4'hA, 3'd7, 3'd0, 3'd7, 1'b1, 1'b0, 3'd7);
    after_edge();
    chk("shr_r7", int'(dbg_data), 8'h00);
    chk("shr_z", int'(flag_z), 1);
    chk("shr_c", int'(flag_c), 1);

    // reset pulsed while a store is pending, with an in-flight instruction
    drv(1'b1, 4'hF, 3'd2, 3'd0, 3'd3, 1'b0, 1'b0, 3'd0);
    after_edge();
    chk("pre_rst_st_valid", int'(st_valid), 1);
    drv(1'b1, 4'hE, 3'd7, 3'd7, 3'd1, 1'b0, 1'b1, 3'd1);
    after_edge();
    chk("post_rst_st_valid", int'(st_valid), 0);
    chk("post_rst_retired", int'(retired), 0);
    chk("post_rst_dec_ready", int'(dec_ready), 1);
    for (int i = 0; i < 8; i++) begin
      drv(1'b0, 4'd0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 3'(i));
      chk("post_rst_reg", int'(dbg_data), 0);
    end

    // randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      drv(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
          3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 299) == 0),
          3'($urandom_range(0, 7)));
    end
    drv(1'b0, 4'd0, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/risc_execute.md
RISC_EXECUTE -- requirements
Module: risc_execute

Interface
REQ-001 SHALL have parameter DW, default 8, meaning the register and ALU data width in bits (DW >= 2).
REQ-002 SHALL have port clk  input  1  system clock; one clock domain, all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have ports dec_valid  input  1, and dec_ready  output  1: decode-to-execute handshake; an instruction is accepted on a clk edge where both are 1.
REQ-005 SHALL have ports opcode  input  4; opnda  input  3; opndb  input  3; dst  input  3: decoded fields (instr[12:9], [8:6], [5:3], [2:0]).
REQ-006 SHALL have ports st_valid  output  1; st_ready  input  1; st_data  output  DW; st_addr  output  3: store output channel.
REQ-007 SHALL have ports flag_z, flag_c, flag_n  output  1 each: zero, carry/borrow and negative flags.
REQ-008 SHALL have ports dbg_sel  input  3 and dbg_data  output  DW: combinational read of R[dbg_sel].
REQ-009 SHALL have port retired  output  16: count of accepted non-NOP instructions.

Function
REQ-010 SHALL hold eight DW-bit registers R0..R7; operands SHALL be read combinationally in the accept cycle; the write SHALL occur on the accept edge (1-cycle latency).
REQ-011 SHALL give an instruction accepted in cycle n the values written by the instruction accepted in cycle n-1, with no stall and no hazard logic.
REQ-012 SHALL decode opcodes: 0000 NOP; 0001 ADD R[d]=R[a]+R[b]; 0010 SUB R[a]-R[b]; 0011 AND; 0100 OR; 0101 XOR; 0110 INC R[a]+1; 0111 DEC R[a]-1.
REQ-013 SHALL decode opcodes: 1000 NOT ~R[a]; 1001 NEG 0-R[a]; 1010 SHR logical right by 1; 1011 SHL left by 1; 1100 ROR; 1101 ROL; 1110 LDI R[d]=zero-extended {opnda,opndb}; 1111 ST.
REQ-014 SHALL compute all results modulo 2^DW.
REQ-015 SHALL set C for ADD and INC to the carry out of bit DW-1.
REQ-016 SHALL set C for SUB and DEC to the borrow (a<b unsigned; a==0 for DEC), and for NEG to (R[a]!=0).
REQ-017 SHALL set C for SHR and ROR to R[a][0], and for SHL and ROL to R[a][DW-1].
REQ-018 SHALL set C to 0 for AND, OR, XOR, NOT and LDI.
REQ-019 SHALL, for every register-writing op, set Z=(result==0) and N=result[DW-1] on the accept edge.
REQ-020 SHALL leave R and all flags unchanged for NOP and ST.
REQ-021 SHALL implement a two-state FSM: RUN (st_valid=0) and ST_WAIT (st_valid=1).
REQ-022 SHALL, on ST accepted in RUN, register st_data=R[opnda] and st_addr=dst and go to ST_WAIT.
REQ-023 SHALL, in ST_WAIT, hold st_data/st_addr stable until st_valid&&st_ready; on that edge it SHALL go to RUN unless a new ST is accepted on the same edge, which SHALL reload st_data/st_addr and stay in ST_WAIT.
REQ-024 SHALL drive dec_ready = (state==RUN) || st_ready; in ST_WAIT with st_ready=0, the decode fields SHALL not be consumed.
REQ-025 SHALL increment retired by 1, wrapping 0xFFFF->0x0000, per accepted instruction with opcode!=0000.

Reset
REQ-026 SHALL, on any edge with rst=1 and regardless of state or handshakes, clear R0..R7, flag_z/c/n, retired and st_data/st_addr to 0, force the FSM to RUN (st_valid=0), and ignore any in-flight dec_valid that edge.
REQ-027 SHALL drive dec_ready=1 in the first cycle after rst deasserts.

Verification
REQ-028 SHALL cover: reset, then LDI a=000 b=101 d=001 -> R1=0x05, Z=0, C=0, N=0, retired=1.
REQ-029 SHALL cover: LDI R1=1, NEG d=2 a=1 -> R2=0xFF, C=1, N=1; then INC d=3 a=2 -> R3=0x00, Z=1, C=1.
REQ-030 SHALL cover: LDI R1=3 and ADD d=2 a=1 b=1 on consecutive cycles -> R2=0x06 on the second edge.
REQ-031 SHALL cover: ST a=2 d=5 with st_ready=0 for 3 cycles -> st_valid=1, st_data=0x06, st_addr=5 held; dec_ready=0; next instruction consumed only on the st_ready edge.
REQ-032 SHALL cover: R1=0x81 via NEG/LDI sequence, ROL -> 0x03, C=1; SHR of 0x01 -> 0x00, Z=1, C=1.
REQ-033 SHALL cover: rst pulsed one cycle while in ST_WAIT -> st_valid=0, all registers 0, retired=0 after that edge.
